// File: rtl/waveform_render_ctrl_if.sv
// -----------------------------------------------------------------------------
// waveform_render_ctrl_if
// Bundles the sample stream, framebuffer write port and status lines of the
// waveform render controller.
//   master : the controller (drives sample_ready, fb_*, status)
//   slave  : the surroundings (drive frame_pulse, sample_valid, sample_data)
// Signals:
//   frame_pulse    one-cycle pulse at start of each VGA frame
//   sample_valid   sample_data valid
//   sample_data    signed sample
//   sample_ready   controller accepts a sample this cycle
//   fb_wr_en       framebuffer write strobe
//   fb_wr_addr     pixel address, y*SCREEN_WIDTH+x
//   fb_wr_data     pixel value (1 = trace, 0 = background)
//   fb_wr_buf      buffer being written (always ~fb_rd_buf)
//   fb_rd_buf      buffer shown by the display path
//   render_busy    frame still incomplete
//   frame_dropped  frame_pulse arrived before the frame was complete
// -----------------------------------------------------------------------------
interface waveform_render_ctrl_if #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int SAMPLE_WIDTH  = 12
);
   localparam int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);

   logic                           frame_pulse;
   logic                           sample_valid;
   logic signed [SAMPLE_WIDTH-1:0] sample_data;
   logic                           sample_ready;
   logic                           fb_wr_en;
   logic [ADDR_W-1:0]              fb_wr_addr;
   logic                           fb_wr_data;
   logic                           fb_wr_buf;
   logic                           fb_rd_buf;
   logic                           render_busy;
   logic                           frame_dropped;

   modport master (
      input  frame_pulse, sample_valid, sample_data,
      output sample_ready, fb_wr_en, fb_wr_addr, fb_wr_data,
             fb_wr_buf, fb_rd_buf, render_busy, frame_dropped
   );

   modport slave (
      output frame_pulse, sample_valid, sample_data,
      input  sample_ready, fb_wr_en, fb_wr_addr, fb_wr_data,
             fb_wr_buf, fb_rd_buf, render_busy, frame_dropped
   );
endinterface

// File: rtl/waveform_render_ctrl.sv
// -----------------------------------------------------------------------------
// waveform_render_ctrl
// Renders one audio frame into the back half of a double-buffered 1-bit
// framebuffer: one signed sample per column, every pixel of the column is
// written (clear and draw in one pass), column-major. Buffers swap on the
// first frame_pulse after the whole frame has been rendered.
// Ports:
//   clk     pixel clock
//   resetn  asynchronous active-low reset
//   bus     waveform_render_ctrl_if.master (sample stream, fb write port,
//           buffer select, status)
// Optional feature macro: THICK_TRACE_EN
//   defined   -> consecutive samples joined by a vertical segment
//   undefined -> single-pixel trace
// -----------------------------------------------------------------------------
module waveform_render_ctrl #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int SAMPLE_WIDTH  = 12,
   parameter int SCALE_SHIFT   = 3
) (
   input  logic                   clk,
   input  logic                   resetn,
   waveform_render_ctrl_if.master bus
);

   localparam int X_W    = $clog2(SCREEN_WIDTH);
   localparam int Y_W    = $clog2(SCREEN_HEIGHT);
   localparam int ADDR_W = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
   localparam int T_W    = SAMPLE_WIDTH + 2;

   localparam logic [X_W-1:0]        X_LAST     = X_W'(SCREEN_WIDTH - 1);
   localparam logic [Y_W-1:0]        Y_LAST     = Y_W'(SCREEN_HEIGHT - 1);
   localparam logic [Y_W-1:0]        Y_MID      = Y_W'(SCREEN_HEIGHT / 2);
   localparam logic [ADDR_W-1:0]     ROW_STRIDE = ADDR_W'(SCREEN_WIDTH);
   localparam logic signed [T_W-1:0] T_MID      = T_W'(SCREEN_HEIGHT / 2);
   localparam logic signed [T_W-1:0] T_MAX      = T_W'(SCREEN_HEIGHT - 1);

   typedef enum logic [1:0] {
      WAIT_SAMPLE = 2'd0,
      COLUMN      = 2'd1,
      DONE        = 2'd2
   } state_t;

   // Map a sample to a row: centre minus the scaled sample (positive plots
   // upward), clamped to the visible rows.
   function automatic logic [Y_W-1:0] map_row(input logic signed [SAMPLE_WIDTH-1:0] s);
      logic signed [T_W-1:0] v;
      logic signed [T_W-1:0] t;
      v = {{2{s[SAMPLE_WIDTH-1]}}, s};
      v = v >>> SCALE_SHIFT;
      t = T_MID - v;
      if (t[T_W-1]) begin
         map_row = {Y_W{1'b0}};
      end else if (t > T_MAX) begin
         map_row = Y_LAST;
      end else begin
         map_row = t[Y_W-1:0];
      end
   endfunction

`ifdef THICK_TRACE_EN
   // Pixel is lit anywhere on the segment joining the previous and current row.
   function automatic logic pixel_on(input logic [Y_W-1:0] y,
                                     input logic [Y_W-1:0] tgt,
                                     input logic [Y_W-1:0] prev);
      logic [Y_W-1:0] lo;
      logic [Y_W-1:0] hi;
      if (tgt < prev) begin
         lo = tgt;
         hi = prev;
      end else begin
         lo = prev;
         hi = tgt;
      end
      pixel_on = (y >= lo) && (y <= hi);
   endfunction
`else
   // Pixel is lit only on the target row.
   function automatic logic pixel_on(input logic [Y_W-1:0] y,
                                     input logic [Y_W-1:0] tgt);
      pixel_on = (y == tgt);
   endfunction
`endif

   state_t            r_state;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;          // row currently presented on the write port
   logic [Y_W-1:0]    r_y_tgt;
   logic              r_fb_wr_en;
   logic [ADDR_W-1:0] r_fb_wr_addr;
   logic              r_fb_wr_data;
   logic              r_fb_wr_buf;
   logic              r_fb_rd_buf;
   logic              r_frame_dropped;

   logic [Y_W-1:0]    w_row_acc;
   logic [Y_W-1:0]    w_y_next;
   logic              w_data_first;
   logic              w_data_next;

   assign w_row_acc = map_row(bus.sample_data);
   assign w_y_next  = r_y + Y_W'(1);

`ifdef THICK_TRACE_EN
   logic [Y_W-1:0]    r_y_prev;
   logic [Y_W-1:0]    w_prev_acc;

   // Column 0 has no predecessor, so it joins to itself.
   assign w_prev_acc   = (r_x == {X_W{1'b0}}) ? w_row_acc : r_y_tgt;
   assign w_data_first = pixel_on({Y_W{1'b0}}, w_row_acc, w_prev_acc);
   assign w_data_next  = pixel_on(w_y_next, r_y_tgt, r_y_prev);
`else
   assign w_data_first = pixel_on({Y_W{1'b0}}, w_row_acc);
   assign w_data_next  = pixel_on(w_y_next, r_y_tgt);
`endif

   // Render sequencer: row 0 is issued on the accept edge so the first write
   // is visible the cycle after valid&ready; the address steps by one row
   // stride per cycle instead of multiplying.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state         <= WAIT_SAMPLE;
         r_x             <= {X_W{1'b0}};
         r_y             <= {Y_W{1'b0}};
         r_y_tgt         <= Y_MID;
         r_fb_wr_en      <= 1'b0;
         r_fb_wr_addr    <= {ADDR_W{1'b0}};
         r_fb_wr_data    <= 1'b0;
         r_fb_wr_buf     <= 1'b1;
         r_fb_rd_buf     <= 1'b0;
         r_frame_dropped <= 1'b0;
`ifdef THICK_TRACE_EN
         r_y_prev        <= Y_MID;
`endif
      end else begin
         r_frame_dropped <= 1'b0;
         case (r_state)
            WAIT_SAMPLE: begin
               if (bus.frame_pulse) begin
                  r_frame_dropped <= 1'b1;
               end
               if (bus.sample_valid) begin
                  r_y_tgt      <= w_row_acc;
`ifdef THICK_TRACE_EN
                  r_y_prev     <= w_prev_acc;
`endif
                  r_y          <= {Y_W{1'b0}};
                  r_fb_wr_en   <= 1'b1;
                  r_fb_wr_addr <= ADDR_W'(r_x);
                  r_fb_wr_data <= w_data_first;
                  r_state      <= COLUMN;
               end else begin
                  r_fb_wr_en   <= 1'b0;
               end
            end
            COLUMN: begin
               if (bus.frame_pulse) begin
                  r_frame_dropped <= 1'b1;
               end
               if (r_y == Y_LAST) begin
                  r_fb_wr_en   <= 1'b0;
                  r_fb_wr_data <= 1'b0;
                  if (r_x == X_LAST) begin
                     r_state <= DONE;
                  end else begin
                     r_x     <= r_x + X_W'(1);
                     r_state <= WAIT_SAMPLE;
                  end
               end else begin
                  r_y          <= w_y_next;
                  r_fb_wr_en   <= 1'b1;
                  r_fb_wr_addr <= r_fb_wr_addr + ROW_STRIDE;
                  r_fb_wr_data <= w_data_next;
               end
            end
            DONE: begin
               r_fb_wr_en <= 1'b0;
               if (bus.frame_pulse) begin
                  r_fb_rd_buf <= ~r_fb_rd_buf;
                  r_fb_wr_buf <= ~r_fb_wr_buf;
                  r_x         <= {X_W{1'b0}};
                  r_state     <= WAIT_SAMPLE;
               end
            end
            default: begin
               r_fb_wr_en <= 1'b0;
               r_state    <= WAIT_SAMPLE;
            end
         endcase
      end
   end

   assign bus.sample_ready  = (r_state == WAIT_SAMPLE);
   assign bus.render_busy   = (r_state != DONE);
   assign bus.fb_wr_en      = r_fb_wr_en;
   assign bus.fb_wr_addr    = r_fb_wr_addr;
   assign bus.fb_wr_data    = r_fb_wr_data;
   assign bus.fb_wr_buf     = r_fb_wr_buf;
   assign bus.fb_rd_buf     = r_fb_rd_buf;
   assign bus.frame_dropped = r_frame_dropped;

endmodule

// File: tb/tb_waveform_render_ctrl.sv
// -----------------------------------------------------------------------------
// tb_waveform_render_ctrl
// Directed bench: a full-size instance (640x480) checks column rendering,
// row mapping/clamping and reset behaviour; a small instance (10x8) checks
// frame completion, buffer swap and dropped-frame reporting.
// -----------------------------------------------------------------------------
module tb_waveform_render_ctrl;

`ifdef THICK_TRACE_EN
   localparam bit THICK = 1'b1;
`else
   localparam bit THICK = 1'b0;
`endif

   localparam int BW = 640;
   localparam int BH = 480;
   localparam int SW = 10;
   localparam int SH = 8;

   typedef struct {
      logic signed [11:0] sample;
      int                 row;
      int                 pulse_at;   // row index at which frame_pulse is raised, 100 = none
   } vec_t;

   logic clk;
   logic resetn;
   int   total;
   int   bad;

   waveform_render_ctrl_if #(.SCREEN_WIDTH(BW), .SCREEN_HEIGHT(BH), .SAMPLE_WIDTH(12)) big_if ();
   waveform_render_ctrl_if #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .SAMPLE_WIDTH(12)) sm_if ();

   waveform_render_ctrl #(.SCREEN_WIDTH(BW), .SCREEN_HEIGHT(BH), .SAMPLE_WIDTH(12), .SCALE_SHIFT(3))
      u_big (.clk(clk), .resetn(resetn), .bus(big_if));

   waveform_render_ctrl #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .SAMPLE_WIDTH(12), .SCALE_SHIFT(3))
      u_small (.clk(clk), .resetn(resetn), .bus(sm_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic calc_span(input int row, input int prev, input int x, output int lo, output int hi);
      lo = row;
      hi = row;
      if (THICK && x != 0) begin
         lo = (row < prev) ? row : prev;
         hi = (row < prev) ? prev : row;
      end
   endtask

   // One column on the full-size instance; called at a negedge, returns at
   // the negedge after the last write.
   task automatic big_column(input logic signed [11:0] s, input int x_exp, input int lo, input int hi);
      int n;
      n = 0;
      while (big_if.sample_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("big_ready_wait", big_if.sample_ready, 1);
      big_if.sample_valid = 1'b1;
      big_if.sample_data  = s;
      @(negedge clk);
      big_if.sample_valid = 1'b0;
      for (int k = 0; k < BH; k++) begin
         if (k > 0) @(negedge clk);
         chk("big_wr_en", big_if.fb_wr_en, 1);
         chk("big_addr", big_if.fb_wr_addr, k * BW + x_exp);
         chk("big_data", big_if.fb_wr_data, (k >= lo && k <= hi) ? 1 : 0);
         chk("big_ready_low", big_if.sample_ready, 0);
      end
      @(negedge clk);
      chk("big_wr_en_end", big_if.fb_wr_en, 0);
      chk("big_ready_next", big_if.sample_ready, (x_exp == BW - 1) ? 0 : 1);
   endtask

   // One column on the small instance, optionally raising frame_pulse for one
   // cycle while row pulse_at is on the write port.
   task automatic sm_column(input logic signed [11:0] s, input int x_exp, input int lo, input int hi,
                            input int pulse_at, input int rd_exp);
      int n;
      n = 0;
      while (sm_if.sample_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("sm_ready_wait", sm_if.sample_ready, 1);
      sm_if.sample_valid = 1'b1;
      sm_if.sample_data  = s;
      @(negedge clk);
      sm_if.sample_valid = 1'b0;
      for (int k = 0; k < SH; k++) begin
         if (k > 0) @(negedge clk);
         sm_if.frame_pulse = 1'b0;
         chk("sm_wr_en", sm_if.fb_wr_en, 1);
         chk("sm_addr", sm_if.fb_wr_addr, k * SW + x_exp);
         chk("sm_data", sm_if.fb_wr_data, (k >= lo && k <= hi) ? 1 : 0);
         chk("sm_ready_low", sm_if.sample_ready, 0);
         chk("sm_dropped", sm_if.frame_dropped, (k == pulse_at + 1) ? 1 : 0);
         chk("sm_rd_buf", sm_if.fb_rd_buf, rd_exp);
         if (k == pulse_at) sm_if.frame_pulse = 1'b1;
      end
      @(negedge clk);
      sm_if.frame_pulse = 1'b0;
      chk("sm_wr_en_end", sm_if.fb_wr_en, 0);
      chk("sm_ready_next", sm_if.sample_ready, (x_exp == SW - 1) ? 0 : 1);
      chk("sm_busy_next", sm_if.render_busy, (x_exp == SW - 1) ? 0 : 1);
      chk("sm_dropped_end", sm_if.frame_dropped, (pulse_at == SH - 1) ? 1 : 0);
      chk("sm_rd_buf_end", sm_if.fb_rd_buf, rd_exp);
   endtask

   initial begin
      vec_t big_vec[8];
      vec_t sm_vec[10];
      int   prev;
      int   lo;
      int   hi;

      // sample >>> 3 subtracted from the centre row, clamped to the screen
      big_vec[0] = '{12'sd0,     240, 100};
      big_vec[1] = '{-12'sd2048, 479, 100};   // 496 clamped
      big_vec[2] = '{12'sd2047,  0,   100};   // -15 clamped
      big_vec[3] = '{12'sd80,    230, 100};
      big_vec[4] = '{-12'sd9,    242, 100};   // -9 >>> 3 = -2
      big_vec[5] = '{12'sd1919,  1,   100};
      big_vec[6] = '{-12'sd1912, 479, 100};   // exactly the bottom row
      big_vec[7] = '{12'sd1927,  0,   100};   // exactly the top row

      sm_vec[0] = '{12'sd0,     4, 100};
      sm_vec[1] = '{-12'sd2048, 7, 100};
      sm_vec[2] = '{12'sd2047,  0, 100};
      sm_vec[3] = '{12'sd16,    2, 3};        // frame_pulse mid-column
      sm_vec[4] = '{-12'sd8,    5, 100};
      sm_vec[5] = '{-12'sd8,    5, 100};
      sm_vec[6] = '{-12'sd8,    5, 100};
      sm_vec[7] = '{-12'sd8,    5, 100};
      sm_vec[8] = '{-12'sd8,    5, 100};
      sm_vec[9] = '{12'sd8,     3, 7};        // frame_pulse with the final write

      total = 0;
      bad   = 0;
      resetn = 1'b0;
      big_if.frame_pulse = 1'b0; big_if.sample_valid = 1'b0; big_if.sample_data = '0;
      sm_if.frame_pulse  = 1'b0; sm_if.sample_valid  = 1'b0; sm_if.sample_data  = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // reset state
      chk("rst_ready", big_if.sample_ready, 1);
      chk("rst_wr_en", big_if.fb_wr_en, 0);
      chk("rst_addr", big_if.fb_wr_addr, 0);
      chk("rst_rd_buf", big_if.fb_rd_buf, 0);
      chk("rst_wr_buf", big_if.fb_wr_buf, 1);
      chk("rst_busy", big_if.render_busy, 1);
      chk("rst_dropped", big_if.frame_dropped, 0);

      // full-size columns from the table
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         calc_span(big_vec[i].row, prev, i, lo, hi);
         big_column(big_vec[i].sample, i, lo, hi);
         prev = big_vec[i].row;
      end

      // small instance: whole frame, two dropped pulses, then the swap
      prev = 0;
      for (int i = 0; i < SW; i++) begin
         calc_span(sm_vec[i].row, prev, i, lo, hi);
         sm_column(sm_vec[i].sample, i, lo, hi, sm_vec[i].pulse_at, 0);
         prev = sm_vec[i].row;
      end
      @(negedge clk);
      chk("done_dropped_clear", sm_if.frame_dropped, 0);
      chk("done_busy", sm_if.render_busy, 0);
      chk("done_ready", sm_if.sample_ready, 0);
      chk("done_rd_buf", sm_if.fb_rd_buf, 0);
      chk("done_wr_buf", sm_if.fb_wr_buf, 1);
      sm_if.sample_valid = 1'b1;
      sm_if.sample_data  = 12'sd0;
      repeat (3) begin
         @(negedge clk);
         chk("done_no_write", sm_if.fb_wr_en, 0);
         chk("done_ready_hold", sm_if.sample_ready, 0);
      end
      sm_if.sample_valid = 1'b0;
      sm_if.frame_pulse  = 1'b1;
      chk("swap_rd_before", sm_if.fb_rd_buf, 0);
      @(negedge clk);
      sm_if.frame_pulse = 1'b0;
      chk("swap_rd_buf", sm_if.fb_rd_buf, 1);
      chk("swap_wr_buf", sm_if.fb_wr_buf, 0);
      chk("swap_busy", sm_if.render_busy, 1);
      chk("swap_ready", sm_if.sample_ready, 1);
      chk("swap_dropped", sm_if.frame_dropped, 0);
      sm_column(12'sd0, 0, 4, 4, 100, 1);

      // reset in the middle of a full-size column
      big_if.sample_valid = 1'b1;
      big_if.sample_data  = 12'sd0;
      @(negedge clk);
      big_if.sample_valid = 1'b0;
      repeat (50) @(negedge clk);
      chk("mid_wr_en", big_if.fb_wr_en, 1);
      #2 resetn = 1'b0;
      #1;
      chk("async_wr_en", big_if.fb_wr_en, 0);
      chk("async_addr", big_if.fb_wr_addr, 0);
      chk("async_sm_rd_buf", sm_if.fb_rd_buf, 0);
      chk("async_sm_wr_buf", sm_if.fb_wr_buf, 1);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rel_ready", big_if.sample_ready, 1);
      chk("rel_wr_en", big_if.fb_wr_en, 0);
      chk("rel_rd_buf", big_if.fb_rd_buf, 0);
      chk("rel_busy", big_if.render_busy, 1);

      // restarts at column 0; second column joins 240 to 250 when thick
      big_column(12'sd0, 0, 240, 240);
      calc_span(250, 240, 1, lo, hi);
      big_column(-12'sd80, 1, lo, hi);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/waveform_render_ctrl.md
Name: waveform_render_ctrl

Overview:
- Sequences rendering of one audio frame into the back half of a double-buffered 1-bit framebuffer: one signed sample per screen column, drawn column-major.
- Every pixel of the column is written each pass, so clearing and drawing happen together.
- Swaps front/back buffers on the VGA frame pulse once a full frame is rendered.
- Sits between the sample stream (decimator output) and the framebuffer write port; the display path reads the buffer selected by fb_rd_buf.

Parameters:
SCREEN_WIDTH, 640, visible columns / samples per frame
SCREEN_HEIGHT, 480, visible rows
SAMPLE_WIDTH, 12, signed sample width
SCALE_SHIFT, 3, arithmetic right shift applied to a sample before mapping it to a row

Ports:
clk  in  1  pixel clock
resetn  in  1  reset; asynchronous, active-low
frame_pulse  in  1  one-cycle pulse at start of each VGA frame
sample_valid  in  1  sample_data valid
sample_data  in  SAMPLE_WIDTH  signed sample
sample_ready  out  1  controller accepts a sample this cycle
fb_wr_en  out  1  framebuffer write strobe
fb_wr_addr  out  $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)  pixel address, y*SCREEN_WIDTH+x
fb_wr_data  out  1  pixel value (1 = trace, 0 = background)
fb_wr_buf  out  1  buffer being written; always ~fb_rd_buf
fb_rd_buf  out  1  buffer shown by the display path
render_busy  out  1  high while the frame is incomplete (state != DONE)
frame_dropped  out  1  one-cycle pulse when frame_pulse arrives before render completes

Behaviour:
- Reset, async on resetn low:
  - state=WAIT_SAMPLE; x=0; y=0.
  - fb_rd_buf=0; fb_wr_buf=1.
  - fb_wr_en=0; fb_wr_addr=0; fb_wr_data=0.
  - frame_dropped=0; sample_ready=1 (combinational from state); render_busy=1.
- All outputs are registered except sample_ready and render_busy, which decode state.
- Row mapping on accept:
  - t = (SCREEN_HEIGHT/2) - (sample_data >>> SCALE_SHIFT), signed, at least SAMPLE_WIDTH+2 bits.
  - Clamp t to [0, SCREEN_HEIGHT-1] and latch it as y_tgt. Positive samples plot upward.
- WAIT_SAMPLE:
  - sample_ready=1, fb_wr_en=0.
  - On sample_valid: latch y_tgt, set y=0, go COLUMN.
- COLUMN:
  - sample_ready=0.
  - Each cycle: fb_wr_en=1, fb_wr_addr=y*SCREEN_WIDTH+x, fb_wr_data=(y==y_tgt).
  - Address is kept incrementally: start at x, add SCREEN_WIDTH per row. No multiplier.
  - At y==SCREEN_HEIGHT-1: if x==SCREEN_WIDTH-1, go DONE; else x=x+1 and go WAIT_SAMPLE.
- Timing:
  - First write appears one cycle after the accept (valid&ready) cycle.
  - A column takes exactly SCREEN_HEIGHT consecutive write cycles.
  - Minimum frame time is SCREEN_WIDTH*(SCREEN_HEIGHT+1) cycles.
- DONE:
  - fb_wr_en=0, sample_ready=0.
  - On frame_pulse: toggle fb_rd_buf and fb_wr_buf, set x=0, go WAIT_SAMPLE.
- frame_pulse in WAIT_SAMPLE or COLUMN:
  - No swap; frame_dropped=1 for one cycle; rendering continues unaffected.
  - This includes frame_pulse arriving in the same cycle as the final pixel write.
- Buffer outputs change only in the cycle after the frame_pulse they respond to.
- Reset mid-column aborts the write immediately: fb_wr_en goes low asynchronously and the partial column is discarded.

Optional Feature:
THICK_TRACE_EN
- Defined:
  - The controller keeps y_prev, the previous column's y_tgt; for column 0, y_prev=y_tgt.
  - fb_wr_data=1 for every y between min(y_prev,y_tgt) and max(y_prev,y_tgt) inclusive, so consecutive samples are joined by a vertical segment.
  - y_prev resets to SCREEN_HEIGHT/2.
- Undefined: single-pixel trace, fb_wr_data=(y==y_tgt) only.
- Timing is identical in both cases.

Test Plan:
- Reset release, no stimulus -> sample_ready=1, fb_wr_en=0, fb_rd_buf=0, fb_wr_buf=1, render_busy=1.
- First sample 0 -> 480 writes to addresses 0,640,...,306560; data=1 only at addr 153600 (y=240); sample_ready low during the 480 cycles.
- Samples -2048 then 2047 (defaults) -> column 0 writes 1 only at y=479 (clamped from 496); column 1 writes 1 only at y=0 (clamped from -15).
- 640 samples streamed back-to-back -> DONE with render_busy=0; next frame_pulse -> fb_rd_buf=1, fb_wr_buf=0 one cycle later; render_busy=1.
- frame_pulse after 100 columns -> frame_dropped high exactly one cycle, fb_rd_buf unchanged, column 100 output unaffected.
- resetn low during column 5 write -> fb_wr_en=0 immediately; after release, first accepted sample renders at x=0, fb_rd_buf=0.
- THICK_TRACE_EN defined, samples 0 then -80 -> column 1 writes 1 for y=240..250, 0 elsewhere.
